// File: rtl/mul4_arb_if.sv
// Handshake and result bus shared by the two multiplier clients and mul4_arb.
// master = client/consumer side, slave = arbiter side.
interface mul4_arb_if;
  logic       req0;
  logic [3:0] x0;
  logic [3:0] y0;
  logic       gnt0;
  logic       req1;
  logic [3:0] x1;
  logic [3:0] y1;
  logic       gnt1;
  logic [7:0] res;
  logic       res_id;
  logic       res_vld;
  logic       res_rdy;
  logic       busy;

  modport master (
    output req0, x0, y0, req1, x1, y1, res_rdy,
    input  gnt0, gnt1, res, res_id, res_vld, busy
  );

  modport slave (
    input  req0, x0, y0, req1, x1, y1, res_rdy,
    output gnt0, gnt1, res, res_id, res_vld, busy
  );
endinterface

// File: rtl/mul4_arb.sv
// Two-requester arbiter/sequencer in front of one shared 4x4 unsigned multiplier.
// MUL4_ARB_RR_EN selects round-robin arbitration; undefined gives fixed priority (req0 wins).
//
// state | meaning
// IDLE  | waiting for a request; grants are issued only here
// MUL   | captured operands are multiplied into res
// OUT   | result held on the bus until res_rdy
module mul4_arb (
  input  logic         clk,
  input  logic         rst,
  mul4_arb_if.slave    bus
);

  typedef enum logic [1:0] {IDLE, MUL, OUT} state_t;

  state_t     state;
  logic [3:0] op_x;
  logic [3:0] op_y;
  logic       op_id;
  logic       g0;
  logic       g1;

`ifdef MUL4_ARB_RR_EN
  logic       last;
`endif

  // Grants are combinational so the winner sees gnt in the capture cycle.
  always_comb begin
    g0 = 1'b0;
    g1 = 1'b0;
    if (!rst && state == IDLE) begin
`ifdef MUL4_ARB_RR_EN
      if (bus.req0 && bus.req1) begin
        g0 = last;
        g1 = ~last;
      end else begin
        g0 = bus.req0;
        g1 = bus.req1;
      end
`else
      g0 = bus.req0;
      g1 = bus.req1 & ~bus.req0;
`endif
    end
  end

  assign bus.gnt0 = g0;
  assign bus.gnt1 = g1;
  assign bus.busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      op_x        <= 4'd0;
      op_y        <= 4'd0;
      op_id       <= 1'b0;
      bus.res     <= 8'd0;
      bus.res_id  <= 1'b0;
      bus.res_vld <= 1'b0;
`ifdef MUL4_ARB_RR_EN
      last        <= 1'b1;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (g0 || g1) begin
            op_x  <= g1 ? bus.x1 : bus.x0;
            op_y  <= g1 ? bus.y1 : bus.y0;
            op_id <= g1;
`ifdef MUL4_ARB_RR_EN
            last  <= g1;
`endif
            state <= MUL;
          end
        end
        MUL: begin
          bus.res     <= {4'd0, op_x} * {4'd0, op_y};
          bus.res_id  <= op_id;
          bus.res_vld <= 1'b1;
          state       <= OUT;
        end
        OUT: begin
          if (bus.res_rdy) begin
            bus.res_vld <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul4_arb.sv
// Directed and randomized self-checking bench for mul4_arb.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_mul4_arb;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  mul4_arb_if bus();

  mul4_arb dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

`ifdef MUL4_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  task automatic idle_inputs();
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    bus.x0 = 4'd0; bus.y0 = 4'd0; bus.x1 = 4'd0; bus.y1 = 4'd0;
    bus.res_rdy = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; idle_inputs(); bus.req0 = 1'b1; bus.req1 = 1'b1; #1;
    checks++;
    if (bus.gnt0 !== 1'b0 || bus.gnt1 !== 1'b0) begin
      failures++;
      $display("FAIL reset_gnt: gnt0=%b gnt1=%b required 0 0", bus.gnt0, bus.gnt1);
    end
    @(negedge clk);
    rst = 1'b0; idle_inputs(); #1;
    checks++;
    if (bus.res !== 8'd0 || bus.res_id !== 1'b0 || bus.res_vld !== 1'b0 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: res=%0d id=%b vld=%b busy=%b required 0 0 0 0",
               bus.res, bus.res_id, bus.res_vld, bus.busy);
    end
  endtask

  // One full operation with res_rdy high: grant in N, MUL in N+1, valid in N+2, IDLE in N+3.
  task automatic run_op(input string nm, input logic r0, input logic r1,
                        input logic [3:0] a0, input logic [3:0] b0,
                        input logic [3:0] a1, input logic [3:0] b1,
                        input logic eid, input logic [7:0] eres);
    @(negedge clk);
    bus.req0 = r0; bus.req1 = r1;
    bus.x0 = a0; bus.y0 = b0; bus.x1 = a1; bus.y1 = b1;
    bus.res_rdy = 1'b1; #1;
    checks++;
    if (bus.gnt0 !== !eid || bus.gnt1 !== eid) begin
      failures++;
      $display("FAIL %s_gnt: gnt0=%b gnt1=%b required %b %b", nm, bus.gnt0, bus.gnt1, !eid, eid);
    end
    @(negedge clk);
    bus.req0 = 1'b0; bus.req1 = 1'b0; #1;
    checks++;
    if (bus.res_vld !== 1'b0 || bus.busy !== 1'b1 || bus.gnt0 !== 1'b0 || bus.gnt1 !== 1'b0) begin
      failures++;
      $display("FAIL %s_mul: vld=%b busy=%b gnt=%b%b required 0 1 00", nm, bus.res_vld, bus.busy,
               bus.gnt0, bus.gnt1);
    end
    @(negedge clk); #1;
    checks++;
    if (bus.res_vld !== 1'b1 || bus.res !== eres || bus.res_id !== eid) begin
      failures++;
      $display("FAIL %s_res: vld=%b res=%0d id=%b required 1 %0d %b", nm, bus.res_vld, bus.res,
               bus.res_id, eres, eid);
    end
    @(negedge clk); #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.res_vld !== 1'b0) begin
      failures++;
      $display("FAIL %s_idle: busy=%b vld=%b required 0 0", nm, bus.busy, bus.res_vld);
    end
  endtask

  task automatic test_single_op();
    run_op("single", 1'b1, 1'b0, 4'd13, 4'd11, 4'd0, 4'd0, 1'b0, 8'd143);
  endtask

  task automatic test_corners();
    run_op("max", 1'b0, 1'b1, 4'd0, 4'd0, 4'd15, 4'd15, 1'b1, 8'd225);
    run_op("zero", 1'b1, 1'b0, 4'd0, 4'd9, 4'd0, 4'd0, 1'b0, 8'd0);
    run_op("one", 1'b1, 1'b0, 4'd1, 4'd7, 4'd0, 4'd0, 1'b0, 8'd7);
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    idle_inputs(); bus.req0 = 1'b1; bus.x0 = 4'd2; bus.y0 = 4'd3; #1;
    checks++;
    if (bus.gnt0 !== 1'b1) begin
      failures++;
      $display("FAIL bp_gnt0: gnt0=%b required 1", bus.gnt0);
    end
    @(negedge clk);
    bus.req0 = 1'b0; bus.req1 = 1'b1; bus.x1 = 4'd5; bus.y1 = 4'd6;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      checks++;
      if (bus.res_vld !== 1'b1 || bus.res !== 8'd6 || bus.res_id !== 1'b0 || bus.gnt1 !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold%0d: vld=%b res=%0d id=%b gnt1=%b required 1 6 0 0", i,
                 bus.res_vld, bus.res, bus.res_id, bus.gnt1);
      end
    end
    bus.res_rdy = 1'b1; #1;
    checks++;
    if (bus.gnt1 !== 1'b0) begin
      failures++;
      $display("FAIL bp_rdy_cycle_gnt1: gnt1=%b required 0", bus.gnt1);
    end
    @(negedge clk); #1;
    checks++;
    if (bus.gnt1 !== 1'b1 || bus.res_vld !== 1'b0) begin
      failures++;
      $display("FAIL bp_release: gnt1=%b vld=%b required 1 0", bus.gnt1, bus.res_vld);
    end
    @(negedge clk);
    bus.req1 = 1'b0;
    @(negedge clk); #1;
    checks++;
    if (bus.res_vld !== 1'b1 || bus.res !== 8'd30 || bus.res_id !== 1'b1) begin
      failures++;
      $display("FAIL bp_second: vld=%b res=%0d id=%b required 1 30 1", bus.res_vld, bus.res, bus.res_id);
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_contention();
    logic eid;
    test_reset();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      bus.req0 = 1'b1; bus.req1 = 1'b1;
      bus.x0 = 4'd3; bus.y0 = 4'd4; bus.x1 = 4'd5; bus.y1 = 4'd7;
      bus.res_rdy = 1'b1; #1;
      eid = RR ? k[0] : 1'b0;
      checks++;
      if (bus.gnt0 !== !eid || bus.gnt1 !== eid) begin
        failures++;
        $display("FAIL cont_gnt%0d: gnt0=%b gnt1=%b required %b %b", k, bus.gnt0, bus.gnt1, !eid, eid);
      end
      @(negedge clk); #1;
      checks++;
      if (bus.gnt0 !== 1'b0 || bus.gnt1 !== 1'b0) begin
        failures++;
        $display("FAIL cont_mulgnt%0d: gnt0=%b gnt1=%b required 0 0", k, bus.gnt0, bus.gnt1);
      end
      @(negedge clk); #1;
      checks++;
      if (bus.res_vld !== 1'b1 || bus.res_id !== eid || bus.res !== (eid ? 8'd35 : 8'd12)) begin
        failures++;
        $display("FAIL cont_res%0d: vld=%b id=%b res=%0d required 1 %b %0d", k, bus.res_vld,
                 bus.res_id, bus.res, eid, eid ? 35 : 12);
      end
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_reset_mid_op();
    @(negedge clk);
    idle_inputs(); bus.req0 = 1'b1; bus.x0 = 4'd9; bus.y0 = 4'd9; bus.res_rdy = 1'b1;
    @(negedge clk);
    bus.req0 = 1'b1; rst = 1'b1; #1;
    checks++;
    if (bus.gnt0 !== 1'b0) begin
      failures++;
      $display("FAIL midrst_gnt: gnt0=%b required 0", bus.gnt0);
    end
    @(negedge clk);
    rst = 1'b0; bus.req0 = 1'b0; #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.res_vld !== 1'b0 || bus.res !== 8'd0) begin
      failures++;
      $display("FAIL midrst_state: busy=%b vld=%b res=%0d required 0 0 0", bus.busy, bus.res_vld, bus.res);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      checks++;
      if (bus.res_vld !== 1'b0) begin
        failures++;
        $display("FAIL midrst_ghost%0d: vld=%b required 0", i, bus.res_vld);
      end
    end
    run_op("after_rst", 1'b1, 1'b0, 4'd6, 4'd7, 4'd0, 4'd0, 1'b0, 8'd42);
  endtask

  task automatic test_random();
    logic       prev_hold = 1'b0;
    logic [7:0] prev_res = 8'd0;
    logic       pend = 1'b0;
    logic [7:0] eres = 8'd0;
    logic       eid = 1'b0;
    int         prod;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      if (prev_hold) begin
        checks++;
        if (bus.res_vld !== 1'b1 || bus.res !== prev_res) begin
          failures++;
          $display("FAIL rnd_stable%0d: vld=%b res=%0d required 1 %0d", c, bus.res_vld, bus.res, prev_res);
        end
      end
      bus.req0 = 1'($urandom_range(1)); bus.req1 = 1'($urandom_range(1));
      bus.x0 = 4'($urandom_range(15)); bus.y0 = 4'($urandom_range(15));
      bus.x1 = 4'($urandom_range(15)); bus.y1 = 4'($urandom_range(15));
      bus.res_rdy = 1'($urandom_range(1));
      #1;
      checks++;
      if ((bus.gnt0 && bus.gnt1) || (bus.busy && (bus.gnt0 || bus.gnt1)) ||
          (bus.gnt0 && !bus.req0) || (bus.gnt1 && !bus.req1)) begin
        failures++;
        $display("FAIL rnd_gnt%0d: gnt=%b%b req=%b%b busy=%b", c, bus.gnt0, bus.gnt1,
                 bus.req0, bus.req1, bus.busy);
      end
      if (bus.res_vld && bus.res_rdy) begin
        checks++;
        if (!pend || bus.res !== eres || bus.res_id !== eid) begin
          failures++;
          $display("FAIL rnd_res%0d: res=%0d id=%b pend=%b required %0d %b", c, bus.res,
                   bus.res_id, pend, eres, eid);
        end
        pend = 1'b0;
      end
      if (bus.gnt0 || bus.gnt1) begin
        prod = bus.gnt1 ? int'(bus.x1) * int'(bus.y1) : int'(bus.x0) * int'(bus.y0);
        eres = prod[7:0];
        eid  = bus.gnt1;
        pend = 1'b1;
      end
      prev_hold = bus.res_vld && !bus.res_rdy;
      prev_res  = bus.res;
    end
    @(negedge clk);
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single_op();
    test_corners();
    test_backpressure();
    test_contention();
    test_reset_mid_op();
    test_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mul4_arb.md
# mul4_arb

Two-requester arbiter and sequencer for the shared 4x4 unsigned multiplier. It grants one requester at a time and captures that requester's operands. It computes the 8-bit product in a registered multiply stage and holds the tagged result on a shared result bus until the consumer accepts it. It sits between the client blocks and the single combinational multiplier, so that multiplier never needs to be duplicated.

## Interface
- Parameters: none. Operands are fixed at 4 bits and the product at 8 bits.
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- req0  in  1  requester 0 operation request
- x0  in  4  requester 0 multiplicand
- y0  in  4  requester 0 multiplier
- gnt0  out  1  requester 0 grant; combinational; operands captured on this edge
- req1  in  1  requester 1 operation request
- x1  in  4  requester 1 multiplicand
- y1  in  4  requester 1 multiplier
- gnt1  out  1  requester 1 grant; combinational
- res  out  8  product, registered
- res_id  out  1  index of the requester that owns res
- res_vld  out  1  res/res_id valid
- res_rdy  in  1  consumer accepts result when high with res_vld
- busy  out  1  high in any state other than IDLE

## Operation
- FSM with three states: IDLE, MUL, OUT.
- IDLE:
  - If req0 or req1 is high, the arbiter picks a winner and asserts its gnt in the same cycle.
  - On the clock edge, the winner's x/y go into op_x/op_y, its index goes into op_id, and the FSM moves to MUL.
  - With no request, the FSM stays in IDLE.
- MUL:
  - res <= op_x * op_y, as an 8-bit unsigned product with no truncation (max 15*15 = 225).
  - res_id <= op_id, res_vld <= 1, then go to OUT.
- OUT:
  - res, res_id and res_vld are held stable.
  - If res_rdy is high, then res_vld <= 0 and the FSM goes to IDLE. Otherwise it stays in OUT indefinitely.
- Grants:
  - gnt0/gnt1 are only ever asserted in IDLE.
  - At most one grant is high in any cycle.
  - A grant is never asserted without the matching req.
- Requester contract:
  - Hold req and operands stable until gnt is seen.
  - Drop req, or present a new operation, in the cycle after gnt.
  - A req still high in the next IDLE is treated as a new operation.
- Arbitration:
  - The policy is selected under Configuration.
  - The last-granted pointer `last` updates only on a grant.
- Reset, which takes priority over everything:
  - state = IDLE, res = 0, res_id = 0, res_vld = 0, last = 1.
  - gnt0 = gnt1 = 0 during the reset cycle.
  - An in-flight operation is discarded and never presented.
- busy is 0 in IDLE and 1 in MUL and OUT.

## Timing
- Grant cycle N (IDLE) -> MUL in cycle N+1 -> res_vld high from cycle N+2.
  - Latency from grant to valid result is 2 cycles.
- If res_rdy is high in the first OUT cycle, IDLE is reached in N+3.
  - The next grant can occur in N+3.
  - Maximum throughput is one operation per 3 cycles.
- res_rdy is ignored while res_vld is low.
- res_rdy is not required to be low in IDLE or MUL.
- Backpressure: res_rdy held low stalls the FSM in OUT.
  - No grants are issued during the stall.
  - Requesters keep waiting.
- Simultaneous req0 and req1 in IDLE are resolved by the arbitration policy.
  - Exactly one grant is issued.
  - The loser keeps req high and is considered again in the next IDLE.

## Configuration
- MUL4_ARB_RR_EN
  - Defined: round-robin arbitration. When both requests are high, the requester with index != last wins.
    - With the reset value last = 1, requester 0 wins the first tie.
    - Two continuously requesting clients are served strictly alternately.
  - Undefined: fixed priority. req0 always wins when high.
    - The `last` register is not implemented.
    - Requester 1 can starve.

## Test plan
- Single op: reset, then req0 with x0=4'd13, y0=4'd11.
  - gnt0 high in cycle N.
  - res_vld high in N+2 with res=8'd143, res_id=0.
  - res_rdy=1 returns the FSM to IDLE in N+3.
- Corner values:
  - x1=15, y1=15 -> res=8'd225, res_id=1.
  - x0=0, y0=9 -> res=0.
  - x0=1, y0=7 -> res=7.
- Backpressure: hold res_rdy=0 for 5 cycles after res_vld rises, with req1 asserted throughout.
  - res, res_id and res_vld stay stable for all 5 cycles.
  - gnt1 stays low until the cycle after res_rdy rises.
- Contention with both reqs held high for 4 operations:
  - With MUL4_ARB_RR_EN, res_id sequence is 0,1,0,1.
  - Without it, res_id sequence is 0,0,0,0 and gnt1 is never asserted.
- Reset mid-op: assert rst in the MUL cycle.
  - Next cycle: busy=0, res_vld=0, res=0.
  - No result for that operation ever appears.
  - A following req0 is granted normally.
- Grant invariants, checked by assertion over 1000 random req/res_rdy cycles:
  - gnt0 and gnt1 are never high together.
  - No grant is high outside IDLE.
  - No grant is high without its req.
  - res is stable whenever res_vld is high and res_rdy is low.
